// File: rtl/poly_ctrl.sv
// poly_ctrl: sequencing and configuration controller for poly_core.
// Generates the 1.79 MHz enable from a phase accumulator and takes CPU
// writes to AUDCTL/SKCTL. It applies those writes to poly_core only on
// enable strobes, serves RANDOM reads and derives the 64 kHz / 15 kHz ticks.
module poly_ctrl #(
    parameter int ACC_W     = 16,
    parameter int PHASE_INC = 2346,
    parameter int DIV64     = 28,
    parameter int DIV15     = 114
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic [7:0] rnd_num,
    output logic       en179,
    output logic       init_o,
    output logic       sel9bit_o,
    output logic       tick64,
    output logic       tick15,
    output logic       base_tick
);

    localparam logic [3:0]     ADDR_AUDCTL = 4'h8;
    localparam logic [3:0]     ADDR_RANDOM = 4'hA;
    localparam logic [3:0]     ADDR_SKCTL  = 4'hF;
    localparam logic [ACC_W:0] INC_EXT     = (ACC_W + 1)'(PHASE_INC);
    localparam int             DIV_MAX     = (DIV15 > DIV64) ? DIV15 : DIV64;
    localparam int             DIV_W       = $clog2(DIV_MAX);

    // ---------------- enable generation ----------------
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             carry_d;
    logic             en179_q;

    assign {carry_d, acc_d} = {1'b0, acc_q} + INC_EXT;

    // Phase accumulator; the carry out becomes the one-clk enable strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            en179_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            en179_q <= carry_d;
        end
    end

    // ---------------- pending and applied configuration ----------------
    logic [1:0] sk_q, sk_d;
    logic [7:0] aud_q, aud_d;
    logic       init_q, init_d;
    logic       sel9_q, sel9_d;
    logic       a0_q, a0_d;

    // Pending registers take CPU writes. The applied copies load from the
    // next pending value on the edge that raises en179. A write sampled on
    // that same edge is applied immediately; a write issued while en179 is
    // already high waits for the following pulse.
    always_comb begin
        sk_d   = sk_q;
        aud_d  = aud_q;
        init_d = init_q;
        sel9_d = sel9_q;
        a0_d   = a0_q;
        if (wr_en) begin
            if (wr_addr == ADDR_SKCTL) begin
                sk_d = wr_data[1:0];
            end
            if (wr_addr == ADDR_AUDCTL) begin
                aud_d = wr_data;
            end
        end
        if (carry_d) begin
            init_d = (sk_d == 2'b00);
            sel9_d = aud_d[7];
            a0_d   = aud_d[0];
        end
    end

    // Configuration state; reset puts poly_core into init.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sk_q   <= 2'b00;
            aud_q  <= 8'h00;
            init_q <= 1'b1;
            sel9_q <= 1'b0;
            a0_q   <= 1'b0;
        end else begin
            sk_q   <= sk_d;
            aud_q  <= aud_d;
            init_q <= init_d;
            sel9_q <= sel9_d;
            a0_q   <= a0_d;
        end
    end

    // The middle AUDCTL bits control the audio channels, not this block.
    logic unused_aud;
    assign unused_aud = ^aud_q[6:1];

    // ---------------- base dividers ----------------
    // Index 0 is the 64 kHz divider, index 1 the 15 kHz divider. Each
    // divider counts enable strobes only while poly_core was out of init
    // during the preceding period. So the strobe that releases init does
    // not count.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_div
            localparam int DIV = (gi == 0) ? DIV64 : DIV15;
            logic [DIV_W-1:0] cnt_q, cnt_d;
            logic             tick_q, tick_d;

            // Next count and tick: a wrap on the last count of the period.
            always_comb begin
                cnt_d  = cnt_q;
                tick_d = 1'b0;
                if (init_q) begin
                    cnt_d = '0;
                end else if (carry_d) begin
                    if (cnt_q == DIV_W'(DIV - 1)) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            // Divider state; the tick is high only alongside en179.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q  <= '0;
                    tick_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    tick_q <= tick_d;
                end
            end
        end
    endgenerate

    // ---------------- register reads ----------------
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q;

    // RANDOM returns all ones while poly_core is held in init. Other
    // addresses read as zero. The data holds until the next read.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            if (rd_addr == ADDR_RANDOM) begin
                rd_data_d = init_q ? 8'hFF : rnd_num;
            end else begin
                rd_data_d = 8'h00;
            end
        end
    end

    // Read response register: one clk of latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en;
        end
    end

    assign en179     = en179_q;
    assign init_o    = init_q;
    assign sel9bit_o = sel9_q;
    assign tick64    = g_div[0].tick_q;
    assign tick15    = g_div[1].tick_q;
    assign base_tick = a0_q ? g_div[1].tick_q : g_div[0].tick_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;

endmodule
